seq_divider: RTL
================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 SHALL have parameter N, default 8, giving divisor and remainder width; dividend and quotient width is 2N.
REQ-002 SHALL have port i_clk  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port i_reset_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port i_start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 SHALL have port i_dividend  input  2N  unsigned dividend; sampled on the accepting edge.
REQ-006 SHALL have port i_divisor  input  N  unsigned divisor; sampled on the accepting edge.
REQ-007 SHALL have port o_quotient  output  2N  registered unsigned quotient.
REQ-008 SHALL have port o_remainder  output  N  registered unsigned remainder.
REQ-009 SHALL have port o_busy  output  1  high in RUN and DONE states.
REQ-010 SHALL have port o_done  output  1  one-cycle pulse; results valid.
REQ-011 SHALL have port o_div_by_zero  output  1  registered flag; set with o_done when the divisor was 0.

Function
REQ-012 SHALL implement an FSM with states IDLE, RUN and DONE.
REQ-013 SHALL accept a request in IDLE on the edge where i_start=1 (edge E0): latch dividend and divisor, clear the N+1-bit partial remainder, clear the iteration counter, and enter RUN.
REQ-014 SHALL perform restoring division in RUN at one quotient bit per cycle, MSB first, for exactly 2N iterations.
REQ-015 SHALL, in each iteration, shift the next dividend bit into the partial remainder; if the partial remainder >= divisor, subtract the divisor and set the quotient bit to 1, else set it to 0.
REQ-016 SHALL hold the partial remainder in N+1 bits internally so that the compare never overflows.
REQ-017 SHALL update o_quotient and o_remainder, assert o_done and enter DONE on edge E0+2N (16 cycles for N=8).
REQ-018 SHALL, in DONE, keep o_done high for that single cycle only and return to IDLE on the next edge.
REQ-019 SHALL hold o_quotient, o_remainder and o_div_by_zero stable from DONE until the next accepted start.
REQ-020 SHALL ignore i_start while in RUN or DONE; there is no queuing and no effect on the current result.
REQ-021 SHALL treat i_start=1 in IDLE on the edge that follows DONE as a new request, giving back-to-back operation.
REQ-022 SHALL handle divisor=0 at acceptance by skipping RUN and entering DONE on edge E0+1, with these results:
- o_quotient = all ones.
- o_remainder = i_dividend[N-1:0].
- o_div_by_zero = 1.
REQ-023 SHALL clear o_div_by_zero on every accepted start with a nonzero divisor.
REQ-024 SHALL keep o_done low at all times other than the single DONE cycle.
REQ-025 SHALL produce results that always satisfy quotient*divisor + remainder = dividend with remainder < divisor for any nonzero divisor.

Reset
REQ-026 SHALL, on i_reset_n low, immediately and regardless of i_clk:
- enter IDLE;
- clear o_quotient, o_remainder, o_busy, o_done and o_div_by_zero to 0;
- clear the counter and partial remainder.
REQ-027 SHALL abort any operation in progress when reset is asserted mid-operation, producing no o_done pulse for it.
REQ-028 SHALL accept a start on the first rising edge after reset deassertion.

Verification
REQ-029 SHALL cover this directed case: dividend 0xFE01, divisor 0xFF -> o_done on edge E0+16, quotient 0x00FF, remainder 0x00, div_by_zero 0.
REQ-030 SHALL cover this directed case: dividend 0x03E8, divisor 0x07 -> quotient 0x008E, remainder 0x06.
REQ-031 SHALL cover this directed case: dividend 0xFFFF, divisor 0x01 -> quotient 0xFFFF, remainder 0x00; then dividend 0x0005, divisor 0xFF -> quotient 0x0000, remainder 0x05.
REQ-032 SHALL cover this directed case: dividend 0x1234, divisor 0x00 -> o_done on edge E0+1, quotient 0xFFFF, remainder 0x34, div_by_zero 1; the following nonzero-divisor op clears div_by_zero.
REQ-033 SHALL cover start held high through RUN: i_dividend changes at E0+5 -> result reflects E0 operands, exactly one o_done, and the next op accepted on the edge after DONE.
REQ-034 SHALL cover these two directed cases:
- Reset asserted at E0+7 -> all outputs 0 immediately and no o_done.
- 1000 random (dividend, divisor != 0) pairs -> the REQ-025 identity holds, with products cross-checked against wallace_tree_multiplier.

Source files
------------

// File: rtl/seq_divider.sv
// Sequential restoring divider: a 2N-bit dividend by an N-bit divisor, one quotient bit per clock.
// A zero divisor short-circuits the iterations and reports a saturated quotient.
module seq_divider #(
    parameter int N = 8
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [2*N-1:0]   i_dividend,
    input  logic [N-1:0]     i_divisor,
    output logic [2*N-1:0]   o_quotient,
    output logic [N-1:0]     o_remainder,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_by_zero
);

    localparam int CW = (2 * N > 1) ? $clog2(2 * N) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(2 * N - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_nxt_s;
    logic [2*N-1:0]   dvd_r, dvd_nxt_s;
    logic [N-1:0]     dsr_r, dsr_nxt_s;
    logic [N:0]       prem_r, prem_nxt_s;
    logic [CW-1:0]    cnt_r, cnt_nxt_s;
    logic             zdiv_r, zdiv_nxt_s;
    logic [2*N-1:0]   quo_r, quo_nxt_s;
    logic [N-1:0]     rem_r, rem_nxt_s;
    logic             busy_r, busy_nxt_s;
    logic             done_r, done_nxt_s;
    logic             dbz_r, dbz_nxt_s;

    logic [N+1:0]     shift_s;
    logic             ge_s;
    logic [N:0]       diff_s;
    logic [N:0]       rem_new_s;
    logic [2*N-1:0]   quo_new_s;

    // One restoring-division step; dvd_r shifts out dividend bits and shifts in quotient bits.
    always_comb begin
        shift_s   = {prem_r, dvd_r[2*N-1]};
        ge_s      = (shift_s >= {2'b00, dsr_r});
        diff_s    = shift_s[N:0] - {1'b0, dsr_r};
        quo_new_s = {dvd_r[2*N-2:0], ge_s};
        if (ge_s) begin
            rem_new_s = diff_s;
        end else begin
            rem_new_s = shift_s[N:0];
        end
    end

    // Next-state and next-value logic for the controller and datapath.
    always_comb begin
        state_nxt_s = state_r;
        dvd_nxt_s   = dvd_r;
        dsr_nxt_s   = dsr_r;
        prem_nxt_s  = prem_r;
        cnt_nxt_s   = cnt_r;
        zdiv_nxt_s  = zdiv_r;
        quo_nxt_s   = quo_r;
        rem_nxt_s   = rem_r;
        dbz_nxt_s   = dbz_r;
        done_nxt_s  = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (i_start) begin
                    dvd_nxt_s   = i_dividend;
                    dsr_nxt_s   = i_divisor;
                    prem_nxt_s  = {(N+1){1'b0}};
                    cnt_nxt_s   = {CW{1'b0}};
                    zdiv_nxt_s  = (i_divisor == {N{1'b0}});
                    state_nxt_s = ST_RUN;
                    if (i_divisor != {N{1'b0}}) begin
                        dbz_nxt_s = 1'b0;
                    end else begin
                        dbz_nxt_s = dbz_r;
                    end
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (zdiv_r) begin
                    // Zero divisor: finish on the first RUN edge with the saturated result.
                    quo_nxt_s   = {(2*N){1'b1}};
                    rem_nxt_s   = dvd_r[N-1:0];
                    dbz_nxt_s   = 1'b1;
                    done_nxt_s  = 1'b1;
                    state_nxt_s = ST_DONE;
                end else begin
                    dvd_nxt_s  = quo_new_s;
                    prem_nxt_s = rem_new_s;
                    cnt_nxt_s  = cnt_r + CW'(1);
                    if (cnt_r == LAST_CNT) begin
                        quo_nxt_s   = quo_new_s;
                        rem_nxt_s   = rem_new_s[N-1:0];
                        done_nxt_s  = 1'b1;
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_RUN;
                    end
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase

        busy_nxt_s = (state_nxt_s != ST_IDLE);
    end

    // State and datapath registers with asynchronous clear.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r <= ST_IDLE;
            dvd_r   <= {(2*N){1'b0}};
            dsr_r   <= {N{1'b0}};
            prem_r  <= {(N+1){1'b0}};
            cnt_r   <= {CW{1'b0}};
            zdiv_r  <= 1'b0;
            quo_r   <= {(2*N){1'b0}};
            rem_r   <= {N{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            dbz_r   <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            dvd_r   <= dvd_nxt_s;
            dsr_r   <= dsr_nxt_s;
            prem_r  <= prem_nxt_s;
            cnt_r   <= cnt_nxt_s;
            zdiv_r  <= zdiv_nxt_s;
            quo_r   <= quo_nxt_s;
            rem_r   <= rem_nxt_s;
            busy_r  <= busy_nxt_s;
            done_r  <= done_nxt_s;
            dbz_r   <= dbz_nxt_s;
        end
    end

    assign o_quotient    = quo_r;
    assign o_remainder   = rem_r;
    assign o_busy        = busy_r;
    assign o_done        = done_r;
    assign o_div_by_zero = dbz_r;

endmodule
